// File: rtl/qe_pkg.sv
// Shared constants for the quadrature front end: Gray states, direction encoding,
// counter widths and the up-step successor helper.
package qe_pkg;

   localparam int QE_CNT_W  = 4;
   localparam int QE_WARM_W = 5;

   localparam logic [1:0] QE_S00 = 2'b00;
   localparam logic [1:0] QE_S10 = 2'b10;
   localparam logic [1:0] QE_S11 = 2'b11;
   localparam logic [1:0] QE_S01 = 2'b01;

   localparam logic QE_UP = 1'b1;
   localparam logic QE_DN = 1'b0;

   // True when {i,q} moved one position forward along 00->10->11->01->00.
   function automatic logic qe_next_up(input logic [1:0] from, input logic [1:0] to);
      logic [1:0] succ;
      case (from)
         QE_S00:  succ = QE_S10;
         QE_S10:  succ = QE_S11;
         QE_S11:  succ = QE_S01;
         QE_S01:  succ = QE_S00;
         default: succ = QE_S00;
      endcase
      return to == succ;
   endfunction

endpackage

// File: rtl/qe_filt.sv
// One encoder channel: two-flop synchroniser followed by a run-length glitch filter.
// Filter present only when QE_FILT_EN is defined; otherwise level follows the synchroniser.
module qe_filt #(
   parameter int FILT_N = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);
   import qe_pkg::*;

   if (FILT_N < 1 || FILT_N >= (1 << QE_CNT_W)) begin : g_bad_filt_n
      $error("qe_filt: FILT_N out of range");
   end

   logic s1;
   logic s2;

   // NOTE: synchronous reset; every flop here, including the synchroniser, starts at 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

`ifdef QE_FILT_EN
   localparam logic [QE_CNT_W-1:0] LIMIT = QE_CNT_W'(FILT_N);
   localparam logic [QE_CNT_W-1:0] ONE   = QE_CNT_W'(1);

   logic [QE_CNT_W-1:0] cnt;

   // Level flips only after FILT_N consecutive synchronised samples disagree with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (s2 == level) begin
         cnt <= '0;
      end else if (cnt + ONE == LIMIT) begin
         level <= s2;
         cnt   <= '0;
      end else begin
         cnt <= cnt + ONE;
      end
   end
`else
   assign level = s2;
`endif

endmodule

// File: rtl/qe_front.sv
// Quadrature front end: filtered i/q levels, step/dir decode and sticky illegal-transition flag.
// Optional glitch filter enabled by defining QE_FILT_EN.
module qe_front #(
   parameter int FILT_N = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   input  logic q_raw,
   input  logic clr,
   output logic i,
   output logic q,
   output logic step,
   output logic dir,
   output logic err
);
   import qe_pkg::*;

`ifdef QE_FILT_EN
   localparam int WARM = FILT_N + 3;
`else
   localparam int WARM = 3;
`endif
   localparam logic [QE_WARM_W-1:0] WARM_LAST = QE_WARM_W'(WARM - 1);
   localparam logic [QE_WARM_W-1:0] WARM_ONE  = QE_WARM_W'(1);

   qe_filt #(.FILT_N(FILT_N)) u_filt_i (.clk(clk), .rst_n(rst_n), .raw(i_raw), .level(i));
   qe_filt #(.FILT_N(FILT_N)) u_filt_q (.clk(clk), .rst_n(rst_n), .raw(q_raw), .level(q));

   logic [1:0]           cur;
   logic [1:0]           prev;
   logic                 armed;
   logic [QE_WARM_W-1:0] wcnt;
   logic                 moved;
   logic                 illegal;

   assign cur = {i, q};

   always_comb begin
      moved   = armed && (cur != prev);
      illegal = moved && ((cur ^ prev) == 2'b11);
   end

   // prev tracks the filtered pair unconditionally, so while unarmed nothing is ever flagged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev  <= QE_S00;
         step  <= 1'b0;
         dir   <= QE_DN;
         err   <= 1'b0;
         armed <= 1'b0;
         wcnt  <= '0;
      end else begin
         prev <= cur;
         step <= moved && !illegal;
         if (moved && !illegal) begin
            dir <= qe_next_up(prev, cur) ? QE_UP : QE_DN;
         end
         if (illegal) begin
            err <= 1'b1;
         end else if (clr) begin
            err <= 1'b0;
         end
         if (!armed) begin
            if (wcnt == WARM_LAST) begin
               armed <= 1'b1;
            end else begin
               wcnt <= wcnt + WARM_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_qe_front.sv
// Scoreboard bench for qe_front: a behavioural model predicts filtered levels and step events,
// a monitor on the falling edge compares every cycle. Follows QE_FILT_EN like the design.
module tb_qe_front;

   localparam int FILT_N = 4;
`ifdef QE_FILT_EN
   localparam int WARM = FILT_N + 3;
   localparam int LAT  = FILT_N + 2;
`else
   localparam int WARM = 3;
   localparam int LAT  = 2;
`endif

   logic clk = 1'b0;
   logic rst_n, i_raw, q_raw, clr;
   logic i, q, step, dir, err;

   qe_front #(.FILT_N(FILT_N)) dut (
      .clk(clk), .rst_n(rst_n), .i_raw(i_raw), .q_raw(q_raw), .clr(clr),
      .i(i), .q(q), .step(step), .dir(dir), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit dir;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;

   // Model state as seen after each rising edge.
   bit [1:0] m_s1, m_s2, m_lvl, m_prev;
   bit       m_dir, m_err;
   int       m_run;
   bit [1:0] hist[$];

   task automatic check(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, req);
      end
   endtask

   // Position of a pair along the up sequence 00,10,11,01.
   function automatic int pos(input bit [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Reference model.
   initial begin
      bit [1:0] old_lvl;
      bit       armed_now, all_diff, bad;
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev = 0; m_dir = 0; m_err = 0; m_run = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev = 0; m_dir = 0; m_err = 0; m_run = 0;
            hist.delete();
         end else begin
            old_lvl   = m_lvl;
            armed_now = (m_run >= WARM);
            hist.push_front(m_s2);
            if (hist.size() > 16) void'(hist.pop_back());
`ifdef QE_FILT_EN
            for (int ch = 0; ch < 2; ch++) begin
               all_diff = (hist.size() >= FILT_N);
               if (all_diff)
                  for (int k = 0; k < FILT_N; k++)
                     if (hist[k][ch] == m_lvl[ch]) all_diff = 0;
               if (all_diff) m_lvl[ch] = ~m_lvl[ch];
            end
`else
            m_lvl = m_s1;
`endif
            m_s2 = m_s1;
            m_s1 = {i_raw, q_raw};
            bad = 0;
            if (armed_now && old_lvl != m_prev) begin
               if ((old_lvl ^ m_prev) == 2'b11) begin
                  bad = 1;
               end else begin
                  m_dir = (pos(old_lvl) == ((pos(m_prev) + 1) % 4));
                  exp_q.push_back('{cyc: cyc, dir: m_dir});
               end
            end
            if (bad) m_err = 1;
            else if (clr) m_err = 0;
            m_prev = old_lvl;
            if (m_run < 1000) m_run++;
         end
      end
   end

   // Monitor: compares on the falling edge, away from DUT updates.
   initial begin
      exp_t e;
      bit   want_step;
      forever begin
         @(negedge clk);
         want_step = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
         check("step", step, want_step);
         if (want_step) begin
            e = exp_q.pop_front();
            check("dir_at_step", dir, e.dir);
         end
         check("dir", dir, m_dir);
         check("i", i, m_lvl[1]);
         check("q", q, m_lvl[0]);
         check("err", err, m_err);
      end
   end

   task automatic drive(input logic [1:0] v, input int n);
      repeat (n) begin
         @(negedge clk);
         {i_raw, q_raw} = v;
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; i_raw = 1'b1; q_raw = 1'b1; clr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // Idle at 11 through reset release: no step, no err.
      drive(2'b11, 20);
      // 11 -> 00 in one move is illegal, then clear.
      drive(2'b00, 15);
      pulse_clr();
      drive(2'b00, 5);
      // Up sequence.
      drive(2'b10, 10); drive(2'b11, 10); drive(2'b01, 10); drive(2'b00, 10);
      // Down sequence.
      drive(2'b01, 10); drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 10);
      // Short glitch on i.
      drive(2'b10, 3); drive(2'b00, 12);
      // Illegal 00 -> 11, clear, then illegal coincident with clr.
      drive(2'b11, 12);
      pulse_clr();
      drive(2'b11, 4);
      @(negedge clk);
      {i_raw, q_raw} = 2'b00;
      repeat (LAT) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      drive(2'b00, 10);
      pulse_clr();
      // Reset mid-sequence while sitting at 11.
      drive(2'b10, 10); drive(2'b11, 10);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b11, 20); drive(2'b01, 10); drive(2'b00, 10);
      // Randomised phase with occasional clear and reset.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if ($urandom_range(7) == 0) i_raw = ~i_raw;
         if ($urandom_range(7) == 0) q_raw = ~q_raw;
         clr   = ($urandom_range(24) == 0);
         rst_n = ($urandom_range(699) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1; clr = 1'b0;
      drive({i_raw, q_raw}, 30);
      repeat (2) @(posedge clk);
      check("pending_steps", exp_q.size() == 0, 1'b1);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/qe_front.md
# qe_front

Synchronous front end for the quadrature position counter: takes raw asynchronous encoder channels, synchronises and glitch-filters them, and decodes legal Gray-code transitions into a one-cycle `step` pulse plus `dir`. Filtered `i`/`q` levels are also driven out so the downstream counter can consume either levels or step/dir. It also flags illegal double-transitions (lost steps) with a sticky error bit.

## Interface
- `FILT_N`, default 4: consecutive clocks a synchronised input must hold a new level before the filtered output follows; legal range 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_raw`  in  1  raw encoder channel I, asynchronous.
- `q_raw`  in  1  raw encoder channel Q, asynchronous.
- `clr`  in  1  synchronous clear of `err`.
- `i`  out  1  filtered channel I level.
- `q`  out  1  filtered channel Q level.
- `step`  out  1  one-cycle pulse per legal quadrature transition.
- `dir`  out  1  direction of the last step: 1 = up (+1), 0 = down (-1); holds between steps.
- `err`  out  1  sticky: illegal transition seen since last `clr`/reset.

## Operation
- Per channel: two-flop synchroniser (`s1`, `s2`), then filter. Filter counter (4 bits) clears whenever `s2` equals the filtered level, increments while different; when it would reach `FILT_N` the filtered level takes `s2` and counter clears.
- Up sequence on {i,q}: 00→10→11→01→00; reverse order is down. Any single-bit change is legal and produces `step`=1 with the matching `dir`.
- Both bits changing in the same cycle (00↔11, 10↔01): no `step`, `dir` unchanged, `err` set.
- `prev` register holds last filtered {i,q}; transition = `prev` vs current filtered {i,q}.
- Warm-up: `armed` flop clears on reset; a warm-up counter sets `armed` after `FILT_N`+3 clocks of `rst_n`=1. While unarmed, `prev` tracks current state every cycle, `step`=0, `err` not set. Prevents spurious steps/errors when inputs idle at non-00 at reset release.
- `err` clears on `clr`=1; an illegal transition in the same cycle as `clr` wins (`err`=1).
- Reset values: `s1`, `s2`, filtered `i`/`q`, filter counters, `prev`, `step`, `dir`, `err`, `armed`, warm-up counter all 0.
- Reset asserted mid-operation: all state returns to reset values on that edge; `step` in flight is dropped.

## Timing
- Edge 0 = first clock edge sampling a new raw level. `s2` shows it after edge 1; filtered output updates at edge 1+`FILT_N`; `step`/`dir`/`err` registered at edge 2+`FILT_N` (edge 6 for default).
- `step` high exactly one cycle per legal transition; back-to-back steps possible on consecutive cycles if filtered levels change on consecutive cycles.
- Raw pulses shorter than `FILT_N` clocks (after synchronisation) never reach `i`/`q`.

## Configuration
- `QE_FILT_EN` defined: filter as above.
- Not defined: filter removed; `i`/`q` = `s2` directly; `step` at edge 2; warm-up = 3 clocks; `FILT_N` ignored.

## Structure
- Package `qe_pkg`: Gray state constants (`QE_S00`, `QE_S10`, `QE_S11`, `QE_S01`), direction constants `QE_UP`=1/`QE_DN`=0, filter counter width 4.
- Sub-module `qe_filt`: one channel's synchroniser + filter, instantiated twice; decoder, warm-up and error logic in the top.

## Test plan
- Reset with `i_raw`=1,`q_raw`=1 held, release → no `step`, `err`=0, `i`=`q`=1 after warm-up.
- Armed at 00, drive 10,11,01,00 with each level held 10 clocks → four `step` pulses, `dir`=1, each at edge 6 after raw change (`FILT_N`=4).
- Reverse sequence 00,01,11,10,00 → four pulses, `dir`=0.
- 3-clock glitch on `i_raw` → `i` unchanged, no `step`.
- Raw 00→11 same edge, held → no `step`, `err`=1; `clr` pulse → `err`=0; illegal event coincident with `clr` → `err`=1.
- `rst_n`=0 mid-sequence at state 11 → all outputs 0 next edge; no spurious `step` after re-arm.
